// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for fifo_sync. It drains LEN words onto a valid/ready
// stream, and a 2-entry skid buffer hides the FIFO's one-cycle read latency.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      word_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                state_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      issued_q;
  logic [LEN_W-1:0]      word_cnt_q;
  logic                  pending_q;
  logic [1:0]            count_q;
  logic [DATA_WIDTH-1:0] buf0_q;
  logic [DATA_WIDTH-1:0] buf1_q;
  logic                  done_q;

  logic                  pop_d;
  logic                  rd_en_d;
  logic [2:0]            occ_d;
  logic [1:0]            slot_d;

  // A read is issued only if the word it returns still has a free buffer slot.
  always_comb begin
    pop_d   = (count_q != 2'd0) & m_ready;
    occ_d   = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop_d};
    rd_en_d = (state_q == S_RUN) & ~fifo_empty & ~flush & (occ_d < 3'd2) &
              (issued_q != len_q);
    slot_d  = count_q - {1'b0, pop_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      word_cnt_q <= '0;
      pending_q  <= 1'b0;
      count_q    <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      pending_q <= rd_en_d;
      count_q   <= count_q + {1'b0, pending_q} - {1'b0, pop_d};
      if (rd_en_d) issued_q <= issued_q + LEN_W'(1);
      if (pop_d) begin
        word_cnt_q <= word_cnt_q + LEN_W'(1);
        buf0_q     <= buf1_q;
      end
      // The returning word lands behind whatever survives this cycle's pop.
      if (pending_q) begin
        if (slot_d == 2'd0) buf0_q <= fifo_data;
        else                buf1_q <= fifo_data;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q      <= len;
            issued_q   <= '0;
            word_cnt_q <= '0;
            if (len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            state_q   <= S_IDLE;
            count_q   <= 2'd0;
            pending_q <= 1'b0;
          end else if (rd_en_d && (issued_q == len_q - LEN_W'(1))) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (flush) begin
            state_q   <= S_IDLE;
            count_q   <= 2'd0;
            pending_q <= 1'b0;
          end else if (pop_d && (word_cnt_q + LEN_W'(1) == len_q)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_cs    = (state_q != S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign fifo_rd_en = rd_en_d;
  assign m_data     = buf0_q;
  assign m_valid    = (count_q != 2'd0);
  assign done       = done_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural fifo_sync read-port model.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic       flush;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_cs;
  logic       fifo_rd_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       done;
  logic [7:0] word_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(8), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_cs(fifo_cs),
    .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .done(done), .word_cnt(word_cnt)
  );

  // fifo_sync read port: registered data one cycle after an accepted read.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && fifo_cs && !fifo_empty) begin
      fifo_data <= mem[rd_ptr % 16];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] v);
    mem[wr_ptr % 16] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic out(input string tag, input logic v, input logic [7:0] d, input logic rd);
    chk({tag, ".m_valid"}, {31'd0, m_valid}, {31'd0, v});
    if (v) chk({tag, ".m_data"}, {24'd0, m_data}, {24'd0, d});
    chk({tag, ".rd_en"}, {31'd0, fifo_rd_en}, {31'd0, rd});
  endtask

  task automatic burst3(input string t);
    push(8'hA5); push(8'h11); push(8'h22);
    nxt(); start = 1'b1; len = 8'd3; m_ready = 1'b1; #1;
    chk({t, ".busy0"}, {31'd0, busy}, 32'd0);
    nxt(); start = 1'b0; #1;
    chk({t, ".busy1"}, {31'd0, busy}, 32'd1);
    chk({t, ".cs1"}, {31'd0, fifo_cs}, 32'd1);
    out({t, ".c1"}, 1'b0, 8'h00, 1'b1);
    nxt(); #1; out({t, ".c2"}, 1'b0, 8'h00, 1'b1);
    nxt(); #1; out({t, ".c3"}, 1'b1, 8'hA5, 1'b1);
    nxt(); #1; out({t, ".c4"}, 1'b1, 8'h11, 1'b0);
    nxt(); #1; out({t, ".c5"}, 1'b1, 8'h22, 1'b0);
    chk({t, ".done_early"}, {31'd0, done}, 32'd0);
    nxt(); #1;
    chk({t, ".m_valid_end"}, {31'd0, m_valid}, 32'd0);
    chk({t, ".done"}, {31'd0, done}, 32'd1);
    chk({t, ".word_cnt"}, {24'd0, word_cnt}, 32'd3);
    nxt(); #1;
    chk({t, ".done_clr"}, {31'd0, done}, 32'd0);
    chk({t, ".idle"}, {31'd0, busy}, 32'd0);
    chk({t, ".word_cnt_hold"}, {24'd0, word_cnt}, 32'd3);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 8'd0; flush = 1'b0; m_ready = 1'b0;
    #12;
    chk("rst.m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst.m_data", {24'd0, m_data}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.cs", {31'd0, fifo_cs}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.word_cnt", {24'd0, word_cnt}, 32'd0);
    rst_n = 1'b1;

    // Basic three-word burst
    burst3("t1");

    // Backpressure: five words, consumer stalls after the first
    push(8'h31); push(8'h32); push(8'h33); push(8'h34); push(8'h35);
    nxt(); start = 1'b1; len = 8'd5; m_ready = 1'b1; #1;
    nxt(); start = 1'b0; #1; out("t2.c1", 1'b0, 8'h00, 1'b1);
    nxt(); #1; out("t2.c2", 1'b0, 8'h00, 1'b1);
    nxt(); #1; out("t2.c3", 1'b1, 8'h31, 1'b1);
    nxt(); m_ready = 1'b0; #1; out("t2.c4", 1'b1, 8'h32, 1'b0);
    nxt(); #1; out("t2.c5", 1'b1, 8'h32, 1'b0);
    nxt(); #1; out("t2.c6", 1'b1, 8'h32, 1'b0);
    nxt(); #1; out("t2.c7", 1'b1, 8'h32, 1'b0);
    chk("t2.wc_stall", {24'd0, word_cnt}, 32'd1);
    nxt(); m_ready = 1'b1; #1; out("t2.c8", 1'b1, 8'h32, 1'b1);
    nxt(); #1; out("t2.c9", 1'b1, 8'h33, 1'b1);
    nxt(); #1; out("t2.c10", 1'b1, 8'h34, 1'b0);
    nxt(); #1; out("t2.c11", 1'b1, 8'h35, 1'b0);
    nxt(); #1;
    chk("t2.done", {31'd0, done}, 32'd1);
    chk("t2.word_cnt", {24'd0, word_cnt}, 32'd5);

    // FIFO runs dry mid-burst, then refills
    nxt(); #1;
    push(8'h50); push(8'h51);
    nxt(); start = 1'b1; len = 8'd4; #1;
    nxt(); start = 1'b0; #1; out("t3.c1", 1'b0, 8'h00, 1'b1);
    nxt(); #1; out("t3.c2", 1'b0, 8'h00, 1'b1);
    nxt(); #1; out("t3.c3", 1'b1, 8'h50, 1'b0);
    nxt(); #1; out("t3.c4", 1'b1, 8'h51, 1'b0);
    nxt(); #1; out("t3.c5", 1'b0, 8'h00, 1'b0);
    chk("t3.stall_busy", {31'd0, busy}, 32'd1);
    chk("t3.stall_wc", {24'd0, word_cnt}, 32'd2);
    nxt(); push(8'h33); push(8'h44); #1; out("t3.c6", 1'b0, 8'h00, 1'b1);
    nxt(); #1; out("t3.c7", 1'b0, 8'h00, 1'b1);
    nxt(); #1; out("t3.c8", 1'b1, 8'h33, 1'b0);
    nxt(); #1; out("t3.c9", 1'b1, 8'h44, 1'b0);
    nxt(); #1;
    chk("t3.done", {31'd0, done}, 32'd1);
    chk("t3.word_cnt", {24'd0, word_cnt}, 32'd4);

    // Zero-length burst with a non-empty FIFO (words reused by the flush test)
    nxt(); #1;
    push(8'h60); push(8'h61); push(8'h62); push(8'h63); push(8'h64); push(8'h65);
    nxt(); start = 1'b1; len = 8'd0; #1;
    chk("t4.rd_en0", {31'd0, fifo_rd_en}, 32'd0);
    nxt(); start = 1'b0; #1;
    chk("t4.done", {31'd0, done}, 32'd1);
    chk("t4.rd_en1", {31'd0, fifo_rd_en}, 32'd0);
    chk("t4.word_cnt", {24'd0, word_cnt}, 32'd0);
    nxt(); #1;
    chk("t4.done_clr", {31'd0, done}, 32'd0);
    chk("t4.rd_en2", {31'd0, fifo_rd_en}, 32'd0);
    chk("t4.idle", {31'd0, busy}, 32'd0);

    // Flush after two of six words
    nxt(); start = 1'b1; len = 8'd6; m_ready = 1'b1; #1;
    nxt(); start = 1'b0; #1; out("t5.c1", 1'b0, 8'h00, 1'b1);
    nxt(); #1; out("t5.c2", 1'b0, 8'h00, 1'b1);
    nxt(); #1; out("t5.c3", 1'b1, 8'h60, 1'b1);
    nxt(); #1; out("t5.c4", 1'b1, 8'h61, 1'b1);
    nxt(); m_ready = 1'b0; flush = 1'b1; #1; out("t5.c5", 1'b1, 8'h62, 1'b0);
    nxt(); flush = 1'b0; m_ready = 1'b1; #1;
    chk("t5.m_valid", {31'd0, m_valid}, 32'd0);
    chk("t5.busy", {31'd0, busy}, 32'd0);
    chk("t5.done", {31'd0, done}, 32'd0);
    chk("t5.word_cnt", {24'd0, word_cnt}, 32'd2);
    nxt(); #1;
    chk("t5.no_done", {31'd0, done}, 32'd0);
    chk("t5.m_valid2", {31'd0, m_valid}, 32'd0);

    // Asynchronous reset mid-burst, then a fresh burst
    nxt(); start = 1'b1; len = 8'd4; m_ready = 1'b0; #1;
    nxt(); start = 1'b0; #1;
    nxt(); #1;
    nxt(); #1; out("t6.pre", 1'b1, 8'h64, 1'b0);
    #2; rst_n = 1'b0; #1;
    chk("t6.m_valid", {31'd0, m_valid}, 32'd0);
    chk("t6.m_data", {24'd0, m_data}, 32'd0);
    chk("t6.busy", {31'd0, busy}, 32'd0);
    chk("t6.cs", {31'd0, fifo_cs}, 32'd0);
    chk("t6.rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("t6.done", {31'd0, done}, 32'd0);
    chk("t6.word_cnt", {24'd0, word_cnt}, 32'd0);
    nxt(); rst_n = 1'b1;
    burst3("t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
